regfile_sb: RTL

//  Parametrised multi-read-port register file with a per-entry pending-write scoreboard.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_sb_scoreboard.sv | 55 +++++
 rtl/regfile_sb.sv | 89 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file slice.
//   addr_w()  : index width for a given entry count (minimum 1 bit)
//   word_t    : data word at the default 32-bit width
//   idx_t     : entry index at the default 32-entry depth
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int AW_DEF = addr_w(DEPTH_DEF);

  typedef logic [WIDTH_DEF-1:0] word_t;
  typedef logic [AW_DEF-1:0]    idx_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: one pending bit per register entry.
//   clk, rst      clock, asynchronous active-low reset (clears every bit)
//   set, set_idx  mark an entry pending (issue side)
//   clr, clr_idx  clear an entry's pending bit (writeback side)
//   rd_idx        NUM_RD packed lookup indices, port i at [i*AW +: AW]
//   busy          pending bit of each looked-up entry, combinational
//   any_busy      OR of every pending bit
// When set and clr hit the same entry in one cycle, set wins: the newly issued
// producer supersedes the one that is writing back.
// With ZERO_REG != 0 entry 0 can never become pending.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic [AW-1:0]        set_idx,
  input  logic                 clr,
  input  logic [AW-1:0]        clr_idx,
  input  logic [NUM_RD*AW-1:0] rd_idx,
  output logic [NUM_RD-1:0]    busy,
  output logic                 any_busy
);

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;

  // Clear first, then set, so a same-index set overrides the clear.
  always_comb begin
    pending_nxt = pending;
    if (clr) pending_nxt[clr_idx] = 1'b0;
    if (set) pending_nxt[set_idx] = 1'b1;
    if (ZERO_REG != 0) pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_nxt;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      busy[i] = pending[rd_idx[i*AW +: AW]];
    end
  end

  assign any_busy = |pending;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x WIDTH register file with NUM_RD combinational read
// ports and a per-entry pending-write scoreboard.
//   clk, rst            clock, asynchronous active-low reset (clears data and pending)
//   wr_en/addr/data     writeback: store data, clear the entry's pending bit
//   sb_set, sb_addr     issue: mark an entry pending
//   rd_addr             NUM_RD packed read indices, port i at [i*AW +: AW]
//   rd_data             NUM_RD packed read words, port i at [i*WIDTH +: WIDTH]
//   rd_busy             pending bit of each read entry
//   any_busy            any entry pending
// wr_en and sb_set are plain single-cycle strobes with no valid/ready
// handshake: each is acted on at every rising edge where it is high, and
// nothing ever back-pressures the producer.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle writeback data
// to matching read ports (and drop their busy unless re-issued that cycle).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    sb_set,
  input  logic [AW-1:0]           sb_addr,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  output logic                    any_busy
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_ok;
  logic [NUM_RD-1:0] sb_busy;

  // Writes to the hardwired zero entry are dropped entirely.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set      (sb_set),
    .set_idx  (sb_addr),
    .clr      (wr_ok),
    .clr_idx  (wr_addr),
    .rd_idx   (rd_addr),
    .busy     (sb_busy),
    .any_busy (any_busy)
  );

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
        rd_data[i*WIDTH +: WIDTH] = '0;
      end else begin
        rd_data[i*WIDTH +: WIDTH] = mem[rd_addr[i*AW +: AW]];
      end
      rd_busy[i] = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
      // wr_ok already excludes the zero entry, so no extra guard here.
      // A same-cycle re-issue keeps the entry busy.
      if (wr_ok && (wr_addr == rd_addr[i*AW +: AW])) begin
        rd_data[i*WIDTH +: WIDTH] = wr_data;
        rd_busy[i] = sb_set && (sb_addr == rd_addr[i*AW +: AW]);
      end
`endif
    end
  end

endmodule
